axi_regfile: RTL and testbench
==============================

Name: axi_regfile

Overview:
- Register file on the register-file side of the AXI register bridge: consumes the bridge's rd/rreg and wr/wreg/wdata strobes and returns read data.
- Provides the following registers:
  - ID and CTRL.
  - Sticky W1C event STATUS with IRQ enable and a registered level interrupt.
  - 64-bit free-running cycle counter with atomic high-word snapshot.
  - SCRATCH and a synchronized GPIO input.

Parameters:
- R_ADDR_WIDTH, 3, register index width; must equal the bridge's; minimum 3.
- N_EVENTS, 8, number of event inputs (1..32).
- ID_VALUE, 32'h5245_4701, constant returned by ID register.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_rreg  in  R_ADDR_WIDTH  read register index (registered by bridge)
- i_rd  in  1  read strobe, one cycle
- o_rdata  out  32  read data
- i_wreg  in  R_ADDR_WIDTH  write register index
- i_wdata  in  32  write data
- i_wr  in  1  write strobe, one cycle
- i_event  in  N_EVENTS  single-cycle event pulses, clk domain
- i_gpio  in  32  asynchronous input pins
- o_ctrl  out  32  CTRL register contents
- o_irq  out  1  level interrupt, registered

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous, active-high; all flops clear on rst assertion.
  - Reset values: o_ctrl=0, STATUS=0, IRQ_EN=0, counter=0, CNT_HI shadow=0, SCRATCH=0, o_irq=0, sync flops=0.
  - o_rdata reflects the reset register values (combinational).
- Register map (index):
  - 0 ID: RO, ID_VALUE.
  - 1 CTRL: RW, drives o_ctrl.
  - 2 STATUS: W1C, bits [N_EVENTS-1:0]; upper bits read 0.
  - 3 IRQ_EN: RW, bits [N_EVENTS-1:0]; upper bits read 0, writes ignored.
  - 4 CNT_LO: RO, counter[31:0].
  - 5 CNT_HI: RO, shadow high word.
  - 6 SCRATCH: RW.
  - 7 GPIO: RO, 2-flop-synchronized i_gpio.
  - Indices >=8 (if R_ADDR_WIDTH>3): read 0, writes ignored.
- Read timing:
  - Bridge presents i_rd/i_rreg after edge N and samples o_rdata at edge N+1.
  - o_rdata is a combinational mux of i_rreg over current register state; no read wait states.
  - o_rdata is valid whether or not i_rd is high.
- Read side effect:
  - At the edge where i_rd=1 and i_rreg=4, the shadow captures counter[63:32] (the same edge the bridge samples CNT_LO).
  - A later read of index 5 returns the high word coherent with that low word.
  - Reading index 5 has no side effect.
- Write timing:
  - Applied at the clock edge where i_wr=1, using i_wreg/i_wdata.
  - Writes to RO registers are ignored.
- Counter:
  - 64-bit, +1 every cycle after reset.
  - Wraps 2^64-1 -> 0.
  - Not writable.
- STATUS:
  - Per bit: next = (status & ~(wr_to_2 ? wdata : 0)) | i_event.
  - An event in the same cycle as a W1C clear of that bit leaves the bit set (set wins).
- IRQ:
  - o_irq <= |(STATUS & IRQ_EN), registered.
  - Asserts one cycle after the enabled status bit sets.
  - Deasserts one cycle after the clear.
- Simultaneous read and write of the same index: read returns the pre-write value; the write takes effect at that edge.
- Reset mid-transaction: state clears immediately; no pending-state recovery is required (the bridge is reset on the same rst).

Decomposition:
- Package axi_regfile_pkg:
  - Register index constants REG_ID..REG_GPIO.
  - Default ID_VALUE.
- Sub-module sync2: parameterized-width 2-flop synchronizer with async active-high reset; used for i_gpio.

Test Plan:
- Reset: assert rst mid-run -> o_ctrl=0, o_irq=0; reads of idx 1,2,3,6 return 0; idx 0 returns 32'h52454701.
- RW: write CTRL=32'hDEADBEEF and SCRATCH=32'h12345678 -> o_ctrl=DEADBEEF the cycle after the wr edge; readback matches; write idx 0 -> ID unchanged.
- W1C/IRQ:
  - Pulse i_event[3] with IRQ_EN=8 -> STATUS=8, o_irq=1 next cycle.
  - Write STATUS=8 -> STATUS=0, o_irq=0 one cycle later.
  - Event[3] coincident with the clear -> STATUS stays 8.
- Counter snapshot:
  - Force the counter near 32'hFFFFFFFF low-word rollover; read CNT_LO, then CNT_HI several cycles later -> the {HI,LO} pair is consistent (no torn value across the carry).
  - HI is unchanged if idx 5 is re-read without an intervening LO read.
- GPIO: drive i_gpio=32'hA5A5_0F0F -> idx 7 reads the new value no earlier than 2 edges after the change.
- Same-cycle read/write of SCRATCH (old=1, new=2) -> the sampled read returns 1; a subsequent read returns 2.

Source files
------------

// File: rtl/axi_regfile_pkg.sv
// Shared constants for the register-file side of the AXI register bridge:
// register indices and the default identification word.
package axi_regfile_pkg;

    localparam int REG_ID      = 0;
    localparam int REG_CTRL    = 1;
    localparam int REG_STATUS  = 2;
    localparam int REG_IRQ_EN  = 3;
    localparam int REG_CNT_LO  = 4;
    localparam int REG_CNT_HI  = 5;
    localparam int REG_SCRATCH = 6;
    localparam int REG_GPIO    = 7;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h5245_4701;

endpackage

// File: rtl/axi_regfile_sync2.sv
// Two-flop synchronizer for quasi-static asynchronous inputs; each bit is
// synchronized independently, so multi-bit values may be seen mid-transition.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments so both stages sample the pre-edge values;
    // blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/axi_regfile.sv
// Register file behind the AXI register bridge: ID, CTRL, W1C STATUS with
// interrupt, 64-bit cycle counter with coherent high-word snapshot, SCRATCH, GPIO.
module axi_regfile
    import axi_regfile_pkg::*;
#(
    parameter int          R_ADDR_WIDTH = 3,
    parameter int          N_EVENTS     = 8,
    parameter logic [31:0] ID_VALUE     = DEFAULT_ID_VALUE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [R_ADDR_WIDTH-1:0] i_rreg,
    input  logic                    i_rd,
    output logic [31:0]             o_rdata,
    input  logic [R_ADDR_WIDTH-1:0] i_wreg,
    input  logic [31:0]             i_wdata,
    input  logic                    i_wr,
    input  logic [N_EVENTS-1:0]     i_event,
    input  logic [31:0]             i_gpio,
    output logic [31:0]             o_ctrl,
    output logic                    o_irq
);

    logic [31:0]         ctrl_q, ctrl_d;
    logic [N_EVENTS-1:0] status_q, status_d;
    logic [N_EVENTS-1:0] irq_en_q, irq_en_d;
    logic [63:0]         cnt_q, cnt_d;
    logic [31:0]         cnt_hi_q, cnt_hi_d;
    logic [31:0]         scratch_q, scratch_d;
    logic                irq_q, irq_d;
    logic [31:0]         gpio_sync;

    logic wr_ctrl, wr_status, wr_irq_en, wr_scratch, rd_cnt_lo;

    assign wr_ctrl    = i_wr && (i_wreg == R_ADDR_WIDTH'(REG_CTRL));
    assign wr_status  = i_wr && (i_wreg == R_ADDR_WIDTH'(REG_STATUS));
    assign wr_irq_en  = i_wr && (i_wreg == R_ADDR_WIDTH'(REG_IRQ_EN));
    assign wr_scratch = i_wr && (i_wreg == R_ADDR_WIDTH'(REG_SCRATCH));
    assign rd_cnt_lo  = i_rd && (i_rreg == R_ADDR_WIDTH'(REG_CNT_LO));

    sync2 #(.WIDTH(32)) u_gpio_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_gpio),
        .o_q (gpio_sync)
    );

    // NOTE: every output gets a default first, so no path through this block
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        cnt_hi_d  = cnt_hi_q;

        if (wr_ctrl)    ctrl_d    = i_wdata;
        if (wr_irq_en)  irq_en_d  = i_wdata[N_EVENTS-1:0];
        if (wr_scratch) scratch_d = i_wdata;

        // An event arriving with a clear of the same bit wins.
        status_d = (status_q & ~(wr_status ? i_wdata[N_EVENTS-1:0] : '0)) | i_event;
        irq_d    = |(status_q & irq_en_q);
        cnt_d    = cnt_q + 64'd1;

        // Snapshot the high word on the same edge the bridge samples CNT_LO.
        if (rd_cnt_lo) cnt_hi_d = cnt_q[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            status_q  <= '0;
            irq_en_q  <= '0;
            cnt_q     <= '0;
            cnt_hi_q  <= '0;
            scratch_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            irq_en_q  <= irq_en_d;
            cnt_q     <= cnt_d;
            cnt_hi_q  <= cnt_hi_d;
            scratch_q <= scratch_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_rreg)
            R_ADDR_WIDTH'(REG_ID):      o_rdata = ID_VALUE;
            R_ADDR_WIDTH'(REG_CTRL):    o_rdata = ctrl_q;
            R_ADDR_WIDTH'(REG_STATUS):  o_rdata = 32'(status_q);
            R_ADDR_WIDTH'(REG_IRQ_EN):  o_rdata = 32'(irq_en_q);
            R_ADDR_WIDTH'(REG_CNT_LO):  o_rdata = cnt_q[31:0];
            R_ADDR_WIDTH'(REG_CNT_HI):  o_rdata = cnt_hi_q;
            R_ADDR_WIDTH'(REG_SCRATCH): o_rdata = scratch_q;
            R_ADDR_WIDTH'(REG_GPIO):    o_rdata = gpio_sync;
            default:                    o_rdata = '0;
        endcase
    end

    assign o_ctrl = ctrl_q;
    assign o_irq  = irq_q;

endmodule

// File: tb/tb_axi_regfile.sv
// Self-checking bench for axi_regfile: read expectations are queued as each
// read is driven and compared when the bridge would sample o_rdata.
module tb_axi_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  i_rreg;
    logic        i_rd;
    logic [31:0] o_rdata;
    logic [2:0]  i_wreg;
    logic [31:0] i_wdata;
    logic        i_wr;
    logic [7:0]  i_event;
    logic [31:0] i_gpio;
    logic [31:0] o_ctrl;
    logic        o_irq;

    axi_regfile #(
        .R_ADDR_WIDTH (3),
        .N_EVENTS     (8),
        .ID_VALUE     (32'h5245_4701)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_rreg  (i_rreg),
        .i_rd    (i_rd),
        .o_rdata (o_rdata),
        .i_wreg  (i_wreg),
        .i_wdata (i_wdata),
        .i_wr    (i_wr),
        .i_event (i_event),
        .i_gpio  (i_gpio),
        .o_ctrl  (o_ctrl),
        .o_irq   (o_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] cyc   = '0;
    logic [63:0] cnt_base;
    logic [63:0] cnt_base_cyc;
    logic [31:0] snap_hi;

    always @(posedge clk) cyc <= cyc + 64'd1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cnt_exp();
        return cnt_base + (cyc - cnt_base_cyc);
    endfunction

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, 64'(o_rdata), 64'(e.exp));
        end
    endtask

    // Inputs change on the falling edge; o_rdata is taken just before the
    // rising edge where the bridge samples it.
    task automatic do_read(input logic [2:0] idx, input string tag, input logic [31:0] exp);
        @(negedge clk);
        i_rd   = 1'b1;
        i_rreg = idx;
        sb_push(tag, exp);
        #4;
        sb_pop_check();
        @(posedge clk);
        #1 i_rd = 1'b0;
    endtask

    task automatic read_cnt_lo(input string tag);
        logic [63:0] full;
        @(negedge clk);
        i_rd   = 1'b1;
        i_rreg = 3'd4;
        full    = cnt_exp();
        snap_hi = full[63:32];
        sb_push(tag, full[31:0]);
        #4;
        sb_pop_check();
        @(posedge clk);
        #1 i_rd = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [31:0] data);
        @(negedge clk);
        i_wr    = 1'b1;
        i_wreg  = idx;
        i_wdata = data;
        @(posedge clk);
        #1 i_wr = 1'b0;
    endtask

    task automatic pulse_event(input logic [7:0] ev);
        @(negedge clk);
        i_event = ev;
        @(posedge clk);
        #1 i_event = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        i_rreg  = '0;
        i_rd    = 1'b0;
        i_wreg  = '0;
        i_wdata = '0;
        i_wr    = 1'b0;
        i_event = '0;
        i_gpio  = '0;
        cnt_base     = '0;
        cnt_base_cyc = '0;
        snap_hi      = '0;
        repeat (3) @(negedge clk);
        rst          = 1'b0;
        cnt_base     = '0;
        cnt_base_cyc = cyc;

        check("rst_ctrl", 64'(o_ctrl), 64'd0);
        check("rst_irq", 64'(o_irq), 64'd0);
        do_read(3'd0, "rst_id", 32'h5245_4701);
        read_cnt_lo("rst_cnt_lo");

        // CTRL / SCRATCH read-write and RO ID.
        do_write(3'd1, 32'hDEAD_BEEF);
        check("ctrl_out", 64'(o_ctrl), 64'h0000_0000_DEAD_BEEF);
        do_write(3'd6, 32'h1234_5678);
        do_read(3'd1, "ctrl_rd", 32'hDEAD_BEEF);
        do_read(3'd6, "scratch_rd", 32'h1234_5678);
        do_write(3'd0, 32'hFFFF_FFFF);
        do_read(3'd0, "id_ro", 32'h5245_4701);
        do_write(3'd3, 32'hFFFF_FFFF);
        do_read(3'd3, "irq_en_mask", 32'h0000_00FF);

        // W1C status and registered interrupt.
        do_write(3'd3, 32'h0000_0008);
        pulse_event(8'h08);
        check("irq_lag", 64'(o_irq), 64'd0);
        @(posedge clk); #1;
        check("irq_set", 64'(o_irq), 64'd1);
        do_read(3'd2, "status_set", 32'h0000_0008);
        do_write(3'd2, 32'h0000_0008);
        check("irq_hold", 64'(o_irq), 64'd1);
        @(posedge clk); #1;
        check("irq_clr", 64'(o_irq), 64'd0);
        do_read(3'd2, "status_clr", 32'h0000_0000);
        pulse_event(8'h01);
        @(posedge clk); #1;
        check("irq_masked", 64'(o_irq), 64'd0);
        do_read(3'd2, "status_bit0", 32'h0000_0001);
        do_write(3'd2, 32'h0000_00FF);
        @(negedge clk);
        i_event = 8'h08;
        i_wr    = 1'b1;
        i_wreg  = 3'd2;
        i_wdata = 32'h0000_0008;
        @(posedge clk);
        #1;
        i_event = '0;
        i_wr    = 1'b0;
        do_read(3'd2, "status_set_wins", 32'h0000_0008);
        check("irq_before_rst", 64'(o_irq), 64'd1);

        // Asynchronous reset mid-run.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 64'(o_ctrl), 64'd0);
        check("mid_rst_irq", 64'(o_irq), 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        cnt_base     = '0;
        cnt_base_cyc = cyc;
        do_read(3'd1, "rst_ctrl_rd", 32'h0);
        do_read(3'd2, "rst_status_rd", 32'h0);
        do_read(3'd3, "rst_irq_en_rd", 32'h0);
        do_read(3'd6, "rst_scratch_rd", 32'h0);
        do_read(3'd0, "rst_id_rd", 32'h5245_4701);

        // Counter snapshot across the low-word carry.
        @(negedge clk);
        force dut.cnt_q = 64'h0000_0001_FFFF_FFF0;
        #1 release dut.cnt_q;
        cnt_base     = 64'h0000_0001_FFFF_FFF0;
        cnt_base_cyc = cyc;
        repeat (10) @(negedge clk);
        read_cnt_lo("cnt_lo_pre_carry");
        repeat (8) @(negedge clk);
        do_read(3'd5, "cnt_hi_coherent", snap_hi);
        do_read(3'd5, "cnt_hi_reread", snap_hi);
        check("cnt_hi_snap_val", 64'(snap_hi), 64'd1);
        read_cnt_lo("cnt_lo_post_carry");
        repeat (3) @(negedge clk);
        do_read(3'd5, "cnt_hi_post_carry", snap_hi);
        check("cnt_hi_snap_val2", 64'(snap_hi), 64'd2);

        // GPIO through the two-flop synchronizer.
        @(negedge clk);
        i_gpio = 32'hA5A5_0F0F;
        i_rreg = 3'd7;
        sb_push("gpio_edge0", 32'h0);
        #4 sb_pop_check();
        @(negedge clk);
        sb_push("gpio_edge1", 32'h0);
        #4 sb_pop_check();
        @(negedge clk);
        sb_push("gpio_edge2", 32'hA5A5_0F0F);
        #4 sb_pop_check();

        // Same-cycle read and write of SCRATCH.
        do_write(3'd6, 32'h1);
        @(negedge clk);
        i_rd    = 1'b1;
        i_rreg  = 3'd6;
        i_wr    = 1'b1;
        i_wreg  = 3'd6;
        i_wdata = 32'h2;
        sb_push("rw_same_old", 32'h1);
        #4 sb_pop_check();
        @(posedge clk);
        #1;
        i_rd = 1'b0;
        i_wr = 1'b0;
        do_read(3'd6, "rw_same_new", 32'h2);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
